// File: rtl/rsg_sequence_ctrl_if.sv
// Control/status bundle for the READY/SET/GO sequencer.
// The sequencer takes the slave modport and its driver takes the master modport.
interface rsg_sequence_ctrl_if;
   logic start;
   logic abort;
   logic hold;
   logic err_clear;
   logic get_ready;
   logic get_set;
   logic get_going;
   logic busy;
   logic done;
   logic state_err;

   modport master (
      output start, abort, hold, err_clear,
      input  get_ready, get_set, get_going, busy, done, state_err
   );

   modport slave (
      input  start, abort, hold, err_clear,
      output get_ready, get_set, get_going, busy, done, state_err
   );
endinterface

// File: rtl/rsg_sequence_ctrl.sv
// Timed READY -> SET -> GO sequencer with per-phase dwell, hold, abort, a done pulse and illegal-state recovery.
// The phase enables decode directly from the state register. done and state_err are registered. hold freezes the dwell counter.
module rsg_sequence_ctrl #(
   parameter int READY_CYCLES = 2,
   parameter int SET_CYCLES   = 3,
   parameter int GO_CYCLES    = 4,
   parameter int CNT_W        = 4
) (
   input  logic               clock,
   input  logic               resetN,
   rsg_sequence_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      READY = 3'b001,
      SET   = 3'b010,
      GO    = 3'b100
   } state_t;

   // The counter is loaded with dwell-1, so a dwell of exactly 2**CNT_W still fits.
   localparam logic [CNT_W-1:0] READY_LD = CNT_W'(READY_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LD   = CNT_W'(SET_CYCLES - 1);
   localparam logic [CNT_W-1:0] GO_LD    = CNT_W'(GO_CYCLES - 1);

   if (READY_CYCLES < 1 || READY_CYCLES > (1 << CNT_W)) begin : g_bad_ready
      $error("READY_CYCLES must be in 1..2**CNT_W");
   end
   if (SET_CYCLES < 1 || SET_CYCLES > (1 << CNT_W)) begin : g_bad_set
      $error("SET_CYCLES must be in 1..2**CNT_W");
   end
   if (GO_CYCLES < 1 || GO_CYCLES > (1 << CNT_W)) begin : g_bad_go
      $error("GO_CYCLES must be in 1..2**CNT_W");
   end

   // The state register is a plain vector so that illegal codes can be represented and caught.
   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             done;
   logic             done_nxt;
   logic             state_err;
   logic             state_err_nxt;
   logic             err_set;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         cnt       <= '0;
         done      <= 1'b0;
         state_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         done      <= done_nxt;
         state_err <= state_err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt = READY;
               cnt_nxt   = READY_LD;
            end
         end
         READY, SET, GO: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (bus.hold) begin
               state_nxt = state;
               cnt_nxt   = cnt;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else if (state == READY) begin
               state_nxt = SET;
               cnt_nxt   = SET_LD;
            end else if (state == SET) begin
               state_nxt = GO;
               cnt_nxt   = GO_LD;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_set   = 1'b1;
         end
      endcase
      // A fresh error outranks a clear that arrives in the same cycle.
      state_err_nxt = err_set | (state_err & ~bus.err_clear);
   end

   assign bus.get_ready = (state == READY);
   assign bus.get_set   = (state == SET);
   assign bus.get_going = (state == GO);
   assign bus.busy      = bus.get_ready | bus.get_set | bus.get_going;
   assign bus.done      = done;
   assign bus.state_err = state_err;

endmodule

// File: tb/tb_rsg_sequence_ctrl.sv
// Directed self-checking bench for rsg_sequence_ctrl at its default dwells (2/3/4).
// The observed vector is {get_ready, get_set, get_going, busy, done, state_err}.
module tb_rsg_sequence_ctrl;

   localparam logic [5:0] V_R = 6'b100100;
   localparam logic [5:0] V_S = 6'b010100;
   localparam logic [5:0] V_G = 6'b001100;
   localparam logic [5:0] V_D = 6'b000010;
   localparam logic [5:0] V_I = 6'b000000;
   localparam logic [5:0] V_E = 6'b000001;

   logic clock;
   logic resetN;
   int   checks;
   int   errors;

   rsg_sequence_ctrl_if bus ();

   rsg_sequence_ctrl #(
      .READY_CYCLES (2),
      .SET_CYCLES   (3),
      .GO_CYCLES    (4),
      .CNT_W        (4)
   ) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   logic [5:0] outs;
   assign outs = {bus.get_ready, bus.get_set, bus.get_going, bus.busy, bus.done, bus.state_err};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_seq(input string tag, input int n, input logic [5:0] v);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         check(tag, 32'(outs), 32'(v));
      end
   endtask

   // Pulse start for one edge and confirm that the first READY cycle follows.
   task automatic kick(input string tag);
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      check(tag, 32'(outs), 32'(V_R));
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      resetN        = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.hold      = 1'b0;
      bus.err_clear = 1'b0;
      #1;
      check("rst_outs", 32'(outs), 32'(V_I));
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;
      expect_seq("rst_idle", 2, V_I);

      // Plain sequence
      kick("t1_ready0");
      expect_seq("t1_ready", 1, V_R);
      expect_seq("t1_set", 3, V_S);
      expect_seq("t1_go", 4, V_G);
      expect_seq("t1_done", 1, V_D);
      expect_seq("t1_idle", 2, V_I);

      // Hold for 5 cycles starting in the 2nd SET cycle
      kick("t2_ready0");
      expect_seq("t2_ready", 1, V_R);
      expect_seq("t2_set_a", 2, V_S);
      bus.hold = 1'b1;
      expect_seq("t2_set_held", 5, V_S);
      bus.hold = 1'b0;
      expect_seq("t2_set_b", 1, V_S);
      expect_seq("t2_go", 4, V_G);
      expect_seq("t2_done", 1, V_D);
      expect_seq("t2_idle", 1, V_I);

      // Abort in the first GO cycle, then start and abort together while idle
      kick("t3_ready0");
      expect_seq("t3_ready", 1, V_R);
      expect_seq("t3_set", 3, V_S);
      expect_seq("t3_go", 1, V_G);
      bus.abort = 1'b1;
      expect_seq("t3_abort", 1, V_I);
      bus.abort = 1'b0;
      expect_seq("t3_no_done", 3, V_I);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      expect_seq("t3_start_abort", 2, V_I);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      expect_seq("t3_idle", 1, V_I);

      // Illegal encoding: raise the error, then clear it
      force dut.state = 3'b011;
      #1;
      check("t4_illegal_decode", 32'(outs), 32'(V_I));
      @(posedge clock);
      #1;
      release dut.state;
      @(negedge clock);
      check("t4_err_set", 32'(outs), 32'(V_E));
      expect_seq("t4_err_sticky", 1, V_E);
      check("t4_state_idle", 32'(dut.state), 32'(0));
      bus.err_clear = 1'b1;
      expect_seq("t4_err_clear", 1, V_I);
      bus.err_clear = 1'b0;
      expect_seq("t4_clean", 1, V_I);

      // Illegal encoding with err_clear in the same cycle: the set wins
      force dut.state = 3'b011;
      bus.err_clear = 1'b1;
      @(posedge clock);
      #1;
      release dut.state;
      @(negedge clock);
      check("t4_set_beats_clear", 32'(bus.state_err), 32'(1));
      bus.err_clear = 1'b0;
      expect_seq("t4_err_hold", 1, V_E);
      check("t4_state_idle2", 32'(dut.state), 32'(0));
      bus.err_clear = 1'b1;
      expect_seq("t4_err_clear2", 1, V_I);
      bus.err_clear = 1'b0;

      // start held high: back-to-back sequences, start while busy is ignored
      bus.start = 1'b1;
      for (int k = 0; k < 2; k++) begin
         expect_seq("t5_ready", 2, V_R);
         expect_seq("t5_set", 3, V_S);
         expect_seq("t5_go", 4, V_G);
         expect_seq("t5_done", 1, V_D);
      end
      bus.start = 1'b0;
      expect_seq("t5_idle", 2, V_I);

      // Asynchronous reset in the 2nd SET cycle
      kick("t6_ready0");
      expect_seq("t6_ready", 1, V_R);
      expect_seq("t6_set", 2, V_S);
      #2;
      resetN = 1'b0;
      #1;
      check("t6_async_rst", 32'(outs), 32'(V_I));
      @(negedge clock);
      check("t6_rst_held", 32'(outs), 32'(V_I));
      resetN = 1'b1;
      expect_seq("t6_idle", 3, V_I);
      kick("t6_restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
